// File: rtl/logic_fifo_synchronous.sv
// Single-clock AXI4-Stream FIFO: CAPACITY-1 entry memory plus a registered first-word-fall-through output stage.
// Latency: a word written into an empty FIFO is presented on tx one cycle after its write edge (bypass into output register).
// Backpressure: rx_tready is registered from the next level and drops when the FIFO is full; tx holds data stable while stalled.
// Optional almost_full/almost_empty flags are enabled by defining LOGIC_FIFO_SYNCHRONOUS_ALMOST_FLAGS_EN.
module logic_fifo_synchronous #(
  parameter int WIDTH        = 1,
  parameter int CAPACITY     = 256,
  parameter int ALMOST_FULL  = CAPACITY - 4,
  parameter int ALMOST_EMPTY = 4
) (
  input  logic                        aclk,
  input  logic                        reset,
  input  logic                        rx_tvalid,
  input  logic [WIDTH-1:0]            rx_tdata,
  output logic                        rx_tready,
  input  logic                        tx_tready,
  output logic                        tx_tvalid,
  output logic [WIDTH-1:0]            tx_tdata,
  output logic [$clog2(CAPACITY):0]   level,
  output logic                        almost_full,
  output logic                        almost_empty
);

  // Memory holds one entry fewer than CAPACITY; the output register is the last slot.
  localparam int DEPTH = CAPACITY - 1;
  localparam int AW    = $clog2(CAPACITY);
  localparam int LW    = AW + 1;
  localparam logic [LW-1:0] CAP_LVL  = LW'(CAPACITY);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  if ((CAPACITY < 8) || ((CAPACITY & (CAPACITY - 1)) != 0)) begin : g_drc_capacity
    $error("logic_fifo_synchronous: CAPACITY must be a power of two and >= 8");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;
  logic             out_load;
  logic             mem_empty;
  logic             mem_wr;
  logic             mem_rd;
  logic [LW-1:0]    level_nxt;

  // Pointers wrap at the memory depth (not a power of two), toggling the wrap bit.
  function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
    if (p[AW-1:0] == LAST_IDX) begin
      return {~p[AW], {AW{1'b0}}};
    end
    return {p[AW], p[AW-1:0] + AW'(1)};
  endfunction

  assign wr_en     = rx_tvalid && rx_tready;
  assign rd_en     = tx_tvalid && tx_tready;
  // Output register may take a new word when it is empty or being drained this edge.
  assign out_load  = !tx_tvalid || rd_en;
  assign mem_empty = (wr_ptr == rd_ptr);
  assign mem_rd    = out_load && !mem_empty;
  // A write bypasses memory only when the output register takes it directly.
  assign mem_wr    = wr_en && !(out_load && mem_empty);

  // Next occupancy: +1 on write only, -1 on read only.
  always_comb begin
    level_nxt = level;
    if (wr_en && !rd_en) begin
      level_nxt = level + LW'(1);
    end else if (!wr_en && rd_en) begin
      level_nxt = level - LW'(1);
    end
  end

  // Pointer, level and registered ready state.
  always_ff @(posedge aclk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rx_tready <= 1'b0;
    end else begin
      if (mem_wr) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (mem_rd) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      level     <= level_nxt;
      rx_tready <= (level_nxt < CAP_LVL);
    end
  end

  // Storage array; contents survive reset since pointers define validity.
  always_ff @(posedge aclk) begin
    if (mem_wr) begin
      mem[wr_ptr[AW-1:0]] <= rx_tdata;
    end
  end

  // Output stage: memory head has priority over bypass to keep FIFO order.
  always_ff @(posedge aclk) begin
    if (reset) begin
      tx_tvalid <= 1'b0;
      tx_tdata  <= '0;
    end else if (out_load) begin
      if (!mem_empty) begin
        tx_tvalid <= 1'b1;
        tx_tdata  <= mem[rd_ptr[AW-1:0]];
      end else if (wr_en) begin
        tx_tvalid <= 1'b1;
        tx_tdata  <= rx_tdata;
      end else begin
        tx_tvalid <= 1'b0;
      end
    end
  end

`ifdef LOGIC_FIFO_SYNCHRONOUS_ALMOST_FLAGS_EN
  if (!((0 < ALMOST_EMPTY) && (ALMOST_EMPTY < ALMOST_FULL) && (ALMOST_FULL < CAPACITY))) begin : g_drc_almost
    $error("logic_fifo_synchronous: need 0 < ALMOST_EMPTY < ALMOST_FULL < CAPACITY");
  end

  // Flags are computed from the next level so they line up with level.
  always_ff @(posedge aclk) begin
    if (reset) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (level_nxt >= LW'(ALMOST_FULL));
      almost_empty <= (level_nxt <= LW'(ALMOST_EMPTY));
    end
  end
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;

  logic unused_almost_cfg;
  assign unused_almost_cfg = ^{ALMOST_FULL, ALMOST_EMPTY};
`endif

endmodule

// File: tb/tb_logic_fifo_synchronous.sv
// Scoreboard bench for logic_fifo_synchronous with WIDTH=8, CAPACITY=8.
// Drivers push accepted words into a queue; a negedge monitor pops and compares on each tx transfer.
// Also tracks expected level, ready/valid and tx stability every cycle.
module tb_logic_fifo_synchronous;

  localparam int W   = 8;
  localparam int CAP = 8;

  logic         aclk;
  logic         reset;
  logic         rx_tvalid;
  logic [W-1:0] rx_tdata;
  logic         rx_tready;
  logic         tx_tready;
  logic         tx_tvalid;
  logic [W-1:0] tx_tdata;
  logic [3:0]   level;
  logic         almost_full;
  logic         almost_empty;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q [$];
  int           mdl_level = 0;
  bit           skip_rdy = 1'b1;
  bit           stall_prev = 1'b0;
  logic [W-1:0] stall_dat = '0;
  bit           stream_phase = 1'b0;
  logic [W-1:0] mon_e;
  bit           mon_wr;
  bit           mon_rd;

`ifdef LOGIC_FIFO_SYNCHRONOUS_ALMOST_FLAGS_EN
  localparam logic AE_RST  = 1'b1;
  localparam logic AF_FULL = 1'b1;
`else
  localparam logic AE_RST  = 1'b0;
  localparam logic AF_FULL = 1'b0;
`endif

  logic_fifo_synchronous #(
    .WIDTH       (W),
    .CAPACITY    (CAP),
    .ALMOST_FULL (4),
    .ALMOST_EMPTY(2)
  ) dut (
    .aclk        (aclk),
    .reset       (reset),
    .rx_tvalid   (rx_tvalid),
    .rx_tdata    (rx_tdata),
    .rx_tready   (rx_tready),
    .tx_tready   (tx_tready),
    .tx_tvalid   (tx_tvalid),
    .tx_tdata    (tx_tdata),
    .level       (level),
    .almost_full (almost_full),
    .almost_empty(almost_empty)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Offer one word until accepted (bounded); push it on acceptance.
  task automatic send(input logic [W-1:0] d);
    bit done;
    done = 1'b0;
    rx_tvalid = 1'b1;
    rx_tdata  = d;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge aclk);
      if (rx_tready) begin
        exp_q.push_back(d);
        done = 1'b1;
      end
      tick();
    end
    rx_tvalid = 1'b0;
    chk("send_accepted", 32'(done), 32'd1);
  endtask

  // Monitor: per-cycle state checks, then scoreboard pop on tx transfers.
  always @(negedge aclk) begin
    chk("level", 32'(level), 32'(mdl_level));
    chk("tx_tvalid", 32'(tx_tvalid), 32'(mdl_level != 0));
    if (!skip_rdy) begin
      chk("rx_tready", 32'(rx_tready), 32'(mdl_level < CAP));
    end
    if (stall_prev) begin
      chk("stall_valid", 32'(tx_tvalid), 32'd1);
      chk("stall_data", 32'(tx_tdata), 32'(stall_dat));
    end
    if (stream_phase) begin
      chk("stream_level_le2", 32'(level <= 4'd2), 32'd1);
    end
    if (reset) begin
      exp_q.delete();
      mdl_level  = 0;
      skip_rdy   = 1'b1;
      stall_prev = 1'b0;
    end else begin
      mon_wr = rx_tvalid && rx_tready;
      mon_rd = tx_tvalid && tx_tready;
      if (mon_rd) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_data: got %0h with empty scoreboard", tx_tdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("tx_data", 32'(tx_tdata), 32'(mon_e));
        end
      end
      mdl_level  = mdl_level + int'(mon_wr) - int'(mon_rd);
      stall_prev = tx_tvalid && !tx_tready;
      stall_dat  = tx_tdata;
      skip_rdy   = 1'b0;
    end
  end

  initial begin
    int accepted;
    reset     = 1'b1;
    rx_tvalid = 1'b0;
    rx_tdata  = '0;
    tx_tready = 1'b0;

    // Reset then idle
    @(posedge aclk);
    @(negedge aclk);
    chk("rst_rx_tready", 32'(rx_tready), 32'd0);
    chk("rst_tx_tdata", 32'(tx_tdata), 32'd0);
    chk("rst_almost_full", 32'(almost_full), 32'd0);
    chk("rst_almost_empty", 32'(almost_empty), 32'(AE_RST));
    tick();
    reset = 1'b0;
    tick();
    @(negedge aclk);
    chk("idle_rx_tready", 32'(rx_tready), 32'd1);
    chk("idle_level", 32'(level), 32'd0);
    tick();

    // Single word with bypass
    tx_tready = 1'b1;
    send(8'h01);
    @(negedge aclk);
    chk("single_tvalid", 32'(tx_tvalid), 32'd1);
    chk("single_tdata", 32'(tx_tdata), 32'h01);
    tick();
    @(negedge aclk);
    chk("single_level_after", 32'(level), 32'd0);
    tick();

    // Fill to full with rx_tvalid held high
    tx_tready = 1'b0;
    accepted  = 0;
    for (int i = 0; i < 10; i++) begin
      rx_tvalid = 1'b1;
      rx_tdata  = 8'(i);
      @(negedge aclk);
      if (rx_tready) begin
        exp_q.push_back(8'(i));
        accepted++;
      end
      tick();
    end
    rx_tvalid = 1'b0;
    @(negedge aclk);
    chk("full_accepted", 32'(accepted), 32'd8);
    chk("full_level", 32'(level), 32'd8);
    chk("full_rx_tready", 32'(rx_tready), 32'd0);
    chk("full_almost_full", 32'(almost_full), 32'(AF_FULL));
    chk("full_head", 32'(tx_tdata), 32'd0);
    tick();
    tx_tready = 1'b1;
    tick();
    tx_tready = 1'b0;
    @(negedge aclk);
    chk("after_full_rx_tready", 32'(rx_tready), 32'd1);
    chk("after_full_level", 32'(level), 32'd7);
    chk("after_full_head", 32'(tx_tdata), 32'd1);
    tick();
    tx_tready = 1'b1;
    repeat (10) tick();
    @(negedge aclk);
    chk("drain1_level", 32'(level), 32'd0);
    tick();

    // Streaming with both sides always ready
    stream_phase = 1'b1;
    tx_tready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      rx_tvalid = 1'b1;
      rx_tdata  = 8'($urandom);
      @(negedge aclk);
      chk("stream_rx_tready", 32'(rx_tready), 32'd1);
      if (rx_tready) begin
        exp_q.push_back(rx_tdata);
      end
      tick();
    end
    rx_tvalid = 1'b0;
    repeat (3) tick();
    stream_phase = 1'b0;

    // Back-pressure: random rx_tvalid, tx_tready at ~30%
    for (int i = 0; i < 400; i++) begin
      rx_tvalid = 1'($urandom_range(0, 1));
      rx_tdata  = 8'($urandom);
      tx_tready = ($urandom_range(0, 9) < 3);
      @(negedge aclk);
      if (rx_tvalid && rx_tready) begin
        exp_q.push_back(rx_tdata);
      end
      tick();
    end
    rx_tvalid = 1'b0;
    tx_tready = 1'b1;
    repeat (20) tick();
    @(negedge aclk);
    chk("bp_drained_level", 32'(level), 32'd0);
    chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);
    tick();

    // Reset mid-stream with 5 words stored
    tx_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(8'(8'h10 + i));
    end
    @(negedge aclk);
    chk("mid_level_before", 32'(level), 32'd5);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge aclk);
    chk("mid_level_after", 32'(level), 32'd0);
    chk("mid_tvalid_after", 32'(tx_tvalid), 32'd0);
    chk("mid_rx_tready_in_reset", 32'(rx_tready), 32'd0);
    tick();
    @(negedge aclk);
    chk("mid_rx_tready_release", 32'(rx_tready), 32'd1);
    tick();
    tx_tready = 1'b1;
    send(8'hA5);
    @(negedge aclk);
    chk("mid_first_word", 32'(tx_tdata), 32'hA5);
    tick();
    repeat (3) tick();
    @(negedge aclk);
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("final_level", 32'(level), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
